// File: rtl/gpio_avalon_irq.sv
// ============================================================================
// Module   : gpio_avalon_irq
// Brief    : Avalon-MM GPIO with synchronised inputs, per-bit output enable,
//            atomic set/clear, and masked edge-capture interrupt.
// Revision : 1.0
// ============================================================================
`default_nettype none

module gpio_avalon_irq #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [3:0]       address,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq,
  input  logic [WIDTH-1:0] gpio_input,
  output logic [WIDTH-1:0] gpio_output,
  output logic [WIDTH-1:0] gpio_oe
);

  localparam logic [3:0] C_ADDR_DATA_IN  = 4'd0;
  localparam logic [3:0] C_ADDR_DATA_OUT = 4'd1;
  localparam logic [3:0] C_ADDR_OUT_SET  = 4'd2;
  localparam logic [3:0] C_ADDR_OUT_CLR  = 4'd3;
  localparam logic [3:0] C_ADDR_DIR      = 4'd4;
  localparam logic [3:0] C_ADDR_RISE_EN  = 4'd5;
  localparam logic [3:0] C_ADDR_FALL_EN  = 4'd6;
  localparam logic [3:0] C_ADDR_EDGE_CAP = 4'd7;
  localparam logic [3:0] C_ADDR_IRQ_MASK = 4'd8;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
  logic [31:0]      readdata_q, readdata_d;

  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_wd;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] w_rd_val;
  logic [31:0]      w_rd_word;

  assign w_sync = sync_q[SYNC_STAGES-1];
  assign w_rise = w_sync & ~prev_q;
  assign w_fall = ~w_sync & prev_q;
  assign w_wd   = writedata[WIDTH-1:0];

  generate
    if (WIDTH < 32) begin : g_unused_wd
      logic unused_wd_hi;
      assign unused_wd_hi = ^writedata[31:WIDTH];
    end
  endgenerate

  always_comb begin
    sync_d[0] = gpio_input;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_comb begin
    data_out_d = data_out_q;
    dir_d      = dir_q;
    rise_en_d  = rise_en_q;
    fall_en_d  = fall_en_q;
    irq_mask_d = irq_mask_q;
    w_clr      = '0;
    if (write) begin
      case (address)
        C_ADDR_DATA_OUT: data_out_d = w_wd;
        C_ADDR_OUT_SET:  data_out_d = data_out_q | w_wd;
        C_ADDR_OUT_CLR:  data_out_d = data_out_q & ~w_wd;
        C_ADDR_DIR:      dir_d      = w_wd;
        C_ADDR_RISE_EN:  rise_en_d  = w_wd;
        C_ADDR_FALL_EN:  fall_en_d  = w_wd;
        C_ADDR_EDGE_CAP: w_clr      = w_wd;
        C_ADDR_IRQ_MASK: irq_mask_d = w_wd;
        default: ;
      endcase
    end
    // New edges are OR-ed in after the clear so a simultaneous set wins.
    edge_cap_d = (edge_cap_q & ~w_clr) | (w_rise & rise_en_q) | (w_fall & fall_en_q);
    prev_d     = w_sync;
  end

  always_comb begin
    w_rd_val = '0;
    case (address)
      C_ADDR_DATA_IN:  w_rd_val = w_sync;
      C_ADDR_DATA_OUT: w_rd_val = data_out_q;
      C_ADDR_DIR:      w_rd_val = dir_q;
      C_ADDR_RISE_EN:  w_rd_val = rise_en_q;
      C_ADDR_FALL_EN:  w_rd_val = fall_en_q;
      C_ADDR_EDGE_CAP: w_rd_val = edge_cap_q;
      C_ADDR_IRQ_MASK: w_rd_val = irq_mask_q;
      default:         w_rd_val = '0;
    endcase
    w_rd_word              = '0;
    w_rd_word[WIDTH-1:0]   = w_rd_val;
    readdata_d             = read ? w_rd_word : readdata_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      prev_q     <= '0;
      data_out_q <= '0;
      dir_q      <= '0;
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      irq_mask_q <= '0;
      edge_cap_q <= '0;
      readdata_q <= '0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      prev_q     <= prev_d;
      data_out_q <= data_out_d;
      dir_q      <= dir_d;
      rise_en_q  <= rise_en_d;
      fall_en_q  <= fall_en_d;
      irq_mask_q <= irq_mask_d;
      edge_cap_q <= edge_cap_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata    = readdata_q;
  assign gpio_output = data_out_q;
  assign gpio_oe     = dir_q;
  assign irq         = |(edge_cap_q & irq_mask_q);

endmodule

`default_nettype wire

// File: tb/tb_gpio_avalon_irq.sv
// ============================================================================
// Module   : tb_gpio_avalon_irq
// Brief    : Directed bench for gpio_avalon_irq (32-bit and 8-bit builds).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_gpio_avalon_irq;

  logic        clk;
  logic        reset_n;
  logic [3:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;

  logic [31:0] readdata_32, readdata_8;
  logic        irq_32, irq_8;
  logic [31:0] gpio_input_32, gpio_output_32, gpio_oe_32;
  logic [7:0]  gpio_input_8, gpio_output_8, gpio_oe_8;

  int vectors;
  int miscompares;
  logic [31:0] rd;

  gpio_avalon_irq #(.WIDTH(32), .SYNC_STAGES(2)) u_dut32 (
    .clk(clk), .reset_n(reset_n), .address(address), .read(read),
    .write(write), .writedata(writedata), .readdata(readdata_32),
    .irq(irq_32), .gpio_input(gpio_input_32), .gpio_output(gpio_output_32),
    .gpio_oe(gpio_oe_32)
  );

  gpio_avalon_irq #(.WIDTH(8), .SYNC_STAGES(2)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .address(address), .read(read),
    .write(write), .writedata(writedata), .readdata(readdata_8),
    .irq(irq_8), .gpio_input(gpio_input_8), .gpio_output(gpio_output_8),
    .gpio_oe(gpio_oe_8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // All bus tasks are entered and left on a falling clock edge.
  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    address = a; writedata = d; write = 1'b1;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    address = a; read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    d = readdata_32;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vectors = 0; miscompares = 0;
    reset_n = 1'b0; address = '0; read = 1'b0; write = 1'b0; writedata = '0;
    gpio_input_32 = '0; gpio_input_8 = '0;
    idle(3);
    check("rst_gpio_output", gpio_output_32, 32'h0);
    check("rst_gpio_oe", gpio_oe_32, 32'h0);
    check("rst_irq", {31'b0, irq_32}, 32'h0);
    check("rst_readdata", readdata_32, 32'h0);
    reset_n = 1'b1;
    idle(1);

    // Data out, set, clear
    bus_write(4'd1, 32'h0000_00A5);
    bus_write(4'd2, 32'h0000_0F00);
    bus_write(4'd3, 32'h0000_0005);
    check("out_after_set_clr", gpio_output_32, 32'h0000_0FA0);
    check("out8_after_set_clr", {24'b0, gpio_output_8}, 32'h0000_00A0);
    bus_read(4'd1, rd);
    check("read_data_out", rd, 32'h0000_0FA0);
    bus_read(4'd2, rd);
    check("read_out_set_zero", rd, 32'h0);
    // Simultaneous read and write returns the pre-write value
    address = 4'd1; writedata = 32'h0000_0123; read = 1'b1; write = 1'b1;
    @(negedge clk);
    read = 1'b0; write = 1'b0;
    check("rw_pre_write", readdata_32, 32'h0000_0FA0);
    check("rw_out_updated", gpio_output_32, 32'h0000_0123);
    bus_write(4'd4, 32'h0000_FF00);
    check("dir_oe", gpio_oe_32, 32'h0000_FF00);

    // Input synchroniser latency
    gpio_input_32 = 32'h3;
    bus_read(4'd0, rd);
    check("data_in_edge1", rd, 32'h0);
    bus_read(4'd0, rd);
    check("data_in_edge2", rd, 32'h0);
    bus_read(4'd0, rd);
    check("data_in_edge3", rd, 32'h3);

    // Rising edge capture on bit 0
    gpio_input_32 = 32'h0;
    idle(5);
    bus_write(4'd5, 32'h1);
    bus_write(4'd8, 32'h1);
    check("no_cap_when_stable", {31'b0, irq_32}, 32'h0);
    gpio_input_32 = 32'h1;
    idle(2);
    check("irq_before_edge3", {31'b0, irq_32}, 32'h0);
    idle(1);
    check("irq_after_edge3", {31'b0, irq_32}, 32'h1);
    bus_read(4'd7, rd);
    check("edge_cap_rise", rd, 32'h1);
    bus_write(4'd7, 32'h1);
    check("irq_after_w1c", {31'b0, irq_32}, 32'h0);
    gpio_input_32 = 32'h0;
    idle(5);
    bus_read(4'd7, rd);
    check("fall_bit0_ignored", rd, 32'h0);

    // Falling edge capture on bit 1, masked then unmasked
    bus_write(4'd6, 32'h2);
    bus_write(4'd8, 32'h0);
    gpio_input_32 = 32'h2;
    idle(5);
    gpio_input_32 = 32'h0;
    idle(5);
    bus_read(4'd7, rd);
    check("edge_cap_fall", rd, 32'h2);
    check("irq_masked", {31'b0, irq_32}, 32'h0);
    bus_write(4'd8, 32'h2);
    check("irq_unmasked", {31'b0, irq_32}, 32'h1);
    bus_write(4'd7, 32'h2);
    check("irq_fall_cleared", {31'b0, irq_32}, 32'h0);

    // Set beats simultaneous W1C
    bus_write(4'd8, 32'h1);
    gpio_input_32 = 32'h1;
    idle(5);
    gpio_input_32 = 32'h0;
    idle(5);
    check("irq_pre_collide", {31'b0, irq_32}, 32'h1);
    gpio_input_32 = 32'h1;
    idle(2);
    bus_write(4'd7, 32'h1);
    check("irq_collide", {31'b0, irq_32}, 32'h1);
    bus_read(4'd7, rd);
    check("edge_cap_collide", rd, 32'h1);

    // 8-bit build: upper bits never stored, unmapped address reads 0
    bus_write(4'd1, 32'hFFFF_FFFF);
    bus_read(4'd1, rd);
    check("w8_data_out", readdata_8, 32'h0000_00FF);
    check("w32_data_out", rd, 32'hFFFF_FFFF);
    bus_read(4'd12, rd);
    check("w8_addr12", readdata_8, 32'h0);
    check("w32_addr12", rd, 32'h0);
    bus_read(4'd1, rd);
    check("w8_reread", readdata_8, 32'h0000_00FF);

    // Asynchronous reset during a read
    address = 4'd1; read = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    check("async_rst_readdata8", readdata_8, 32'h0);
    check("async_rst_out8", {24'b0, gpio_output_8}, 32'h0);
    check("async_rst_irq32", {31'b0, irq_32}, 32'h0);
    @(posedge clk);
    #1;
    check("rst_hold_readdata32", readdata_32, 32'h0);
    read = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/gpio_avalon_irq.md
Name: gpio_avalon_irq

Overview:
Parametrised Avalon-MM GPIO peripheral for the Nios-II `cpu_system`. It is the successor to the fixed input/output GPIO port currently wired to `sw` and `ledr`. It adds:
- synchronised inputs;
- per-bit output enable;
- atomic set and clear writes for outputs;
- per-bit rising/falling edge capture with a masked interrupt.

It sits on the CPU data bus and exports `gpio_input`, `gpio_output` and `gpio_oe` to the board top.

Parameters:
- WIDTH, 32, number of GPIO bits (1..32).
- SYNC_STAGES, 2, input synchroniser depth (>=2).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- address  in  4  word address
- read  in  1  read strobe
- write  in  1  write strobe
- writedata  in  32  write data; bits >= WIDTH ignored
- readdata  out  32  read data; bits >= WIDTH are 0
- irq  out  1  level interrupt to the CPU
- gpio_input  in  WIDTH  asynchronous pin inputs
- gpio_output  out  WIDTH  output data register
- gpio_oe  out  WIDTH  per-bit output enable (1 = drive)

Behaviour:
- Reset:
  - reset_n low clears every register immediately and asynchronously: DATA_OUT, DIR, RISE_EN, FALL_EN, IRQ_MASK, EDGE_CAP, sync chain, prev-sample register, readdata.
  - Consequently gpio_output=0, gpio_oe=0, irq=0, readdata=0.
  - Reset asserted mid-transaction aborts that transaction. No register update survives.
- Bus protocol:
  - No waitrequest; fixed read latency 1.
  - read high at edge N → readdata valid after edge N and held until the next read.
  - A write takes effect at the edge where write is high.
  - read and write high together: the write takes effect; readdata returns the pre-write value.
- Address map (R = read, W = write):
  - 0 DATA_IN: RO, synchronised inputs.
  - 1 DATA_OUT: RW.
  - 2 OUT_SET: W, DATA_OUT |= wd; reads 0.
  - 3 OUT_CLR: W, DATA_OUT &= ~wd; reads 0.
  - 4 DIR: RW, drives gpio_oe.
  - 5 RISE_EN: RW.
  - 6 FALL_EN: RW.
  - 7 EDGE_CAP: R, write-1-to-clear.
  - 8 IRQ_MASK: RW.
  - 9-15: read 0; writes ignored.
- Input path:
  - gpio_input passes through a SYNC_STAGES flop chain; sync_q is the last stage.
  - prev holds sync_q delayed by one cycle.
  - rise = sync_q & ~prev; fall = ~sync_q & prev.
  - DATA_IN reflects sync_q: a pin change before edge 1 is visible after edge SYNC_STAGES.
- Edge capture:
  - Each edge: EDGE_CAP[i] <= (EDGE_CAP[i] & ~clr[i]) | (rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i]).
  - clr is writedata when writing address 7, else 0.
  - A bit set takes priority over a W1C clear of that bit in the same cycle; the bit stays 1.
  - Edges are captured on every bit regardless of DIR.
  - Enabling RISE_EN/FALL_EN while an input is already stable creates no capture, because prev tracks continuously.
  - Pin change before edge 1 → EDGE_CAP set after edge SYNC_STAGES+1.
- irq = |(EDGE_CAP & IRQ_MASK), combinational from registers only.
  - Stays asserted until every masked captured bit is cleared or masked off.
- gpio_output = DATA_OUT and gpio_oe = DIR, both straight from registers with no extra latency.
- Bits >= WIDTH: never stored; always read as 0.

Test Plan:
1. Reset release → all outputs 0. Write DATA_OUT=0x0000_00A5, then OUT_SET 0x0F00, then OUT_CLR 0x0005 → gpio_output=0x0F_A0; read addr 1 returns 0x0000_0FA0 one cycle after the read.
2. Drive gpio_input=0x3 with SYNC_STAGES=2 → read DATA_IN returns 0x3 once two edges have passed; a read issued before that returns 0x0.
3. RISE_EN=0x1, IRQ_MASK=0x1; pulse gpio_input[0] 0→1 → EDGE_CAP=0x1 after 3 edges and irq=1. W1C 0x1 → irq=0. A falling edge on bit 0 does not set the bit.
4. FALL_EN=0x2, IRQ_MASK=0; falling edge on bit 1 → EDGE_CAP=0x2 and irq=0. Then write IRQ_MASK=0x2 → irq=1 the cycle after the write.
5. Rising edge on bit 0 arriving at the same edge as a W1C write of 0x1 → EDGE_CAP[0] stays 1 and irq stays high.
6. WIDTH=8 build: write DATA_OUT=0xFFFF_FFFF → read returns 0x0000_00FF. Read address 12 → 0. Assert reset_n mid-read → readdata=0 immediately.
